// File: rtl/sp_pkg.sv
// rtl/sp_pkg.sv - shared state encoding and helpers for the sweep tracker
// Purpose: state enum used by sweep_tracker (also exported on STAT) and a
//          ceil-log2 helper used to size the position and counter registers.
// Ports:   none (package).
package sp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOME   = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_STEP   = 3'd4,
        ST_RETURN = 3'd5,
        ST_TRACK  = 3'd6
    } state_t;

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sweep_axis.sv
// rtl/sweep_axis.sv - one servo axis: position model plus registered step pulse
// Purpose: tracks the mount position on one axis and registers the MOVE/DIR
//          pulse to the servo driver. The position changes on the same edge
//          that raises the pulse, so position and pulse stay in lockstep.
// Ports:   clk, rst        - clock, asynchronous active-high reset
//          step_req, step_dir - request one step this cycle (dir 1 = up)
//          target          - coordinate compared for at_target
//          pos             - current position model
//          move, dir       - registered one-cycle step pulse and direction
//          at_min, at_max, at_target - position flags
module sweep_axis
    import sp_pkg::*;
#(
    parameter int STEPS = 16,
    parameter int W     = clog2(STEPS)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step_req,
    input  logic         step_dir,
    input  logic [W-1:0] target,
    output logic [W-1:0] pos,
    output logic         move,
    output logic         dir,
    output logic         at_min,
    output logic         at_max,
    output logic         at_target
);

    localparam logic [W-1:0] MAX_POS = W'(STEPS - 1);

    logic [W-1:0] pos_q, pos_d;
    logic         move_q, move_d;
    logic         dir_q, dir_d;

    always_comb begin
        pos_d  = pos_q;
        move_d = step_req;
        dir_d  = step_req ? step_dir : 1'b0;
        if (step_req) begin
            pos_d = step_dir ? pos_q + W'(1) : pos_q - W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q  <= '0;
            move_q <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            pos_q  <= pos_d;
            move_q <= move_d;
            dir_q  <= dir_d;
        end
    end

    assign pos       = pos_q;
    assign move      = move_q;
    assign dir       = dir_q;
    assign at_min    = (pos_q == '0);
    assign at_max    = (pos_q == MAX_POS);
    assign at_target = (pos_q == target);

endmodule

// File: rtl/sweep_tracker.sv
// rtl/sweep_tracker.sv - raster sun search followed by peak tracking for a two-axis mount
// Purpose: homes the mount, sweeps a serpentine STEPS_H x STEPS_V grid sampling
//          the panel voltage at each point, returns to the best point and
//          tracks there, rescanning after MISS_MAX consecutive low samples
//          or on START while tracking.
// Ports:   CLK, RESET          - clock, asynchronous active-high reset
//          TICK                - one-cycle step strobe
//          START               - level request to (re)scan
//          V_IN, V_VALID       - panel voltage sample and its strobe
//          MOVE_H/V, DIR_H/V   - registered step pulses to the servo drivers
//          BUSY, DONE          - scanning flag, one-cycle pulse on entry to TRACK
//          PEAK_V, PEAK_H_POS, PEAK_V_POS - stored best voltage and its coordinates
//          STAT                - current state encoding
module sweep_tracker
    import sp_pkg::*;
#(
    parameter int V_WIDTH  = 12,
    parameter int STEPS_H  = 16,
    parameter int STEPS_V  = 8,
    parameter int SETTLE   = 4,
    parameter int HYST     = 8,
    parameter int MISS_MAX = 3
) (
    input  logic                      CLK,
    input  logic                      RESET,
    input  logic                      TICK,
    input  logic                      START,
    input  logic [V_WIDTH-1:0]        V_IN,
    input  logic                      V_VALID,
    output logic                      MOVE_H,
    output logic                      MOVE_V,
    output logic                      DIR_H,
    output logic                      DIR_V,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [V_WIDTH-1:0]        PEAK_V,
    output logic [clog2(STEPS_H)-1:0] PEAK_H_POS,
    output logic [clog2(STEPS_V)-1:0] PEAK_V_POS,
    output logic [2:0]                STAT
);

    localparam int HW = clog2(STEPS_H);
    localparam int VW = clog2(STEPS_V);
    localparam int SW = clog2(SETTLE + 1);
    localparam int MW = clog2(MISS_MAX + 1);

    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [MW-1:0]      MISS_LAST   = MW'(MISS_MAX - 1);
    localparam logic [V_WIDTH:0]   HYST_EXT    = (V_WIDTH + 1)'(HYST);

    state_t               state_q, state_d;
    logic [SW-1:0]        settle_q, settle_d;
    logic [MW-1:0]        miss_q, miss_d;
    logic [V_WIDTH-1:0]   peak_v_q, peak_v_d;
    logic [HW-1:0]        peak_h_q, peak_h_d;
    logic [VW-1:0]        peak_vp_q, peak_vp_d;
    logic                 done_q, done_d;

    logic                 step_h, dir_h_req, step_v, dir_v_req;
    logic [HW-1:0]        h_pos;
    logic [VW-1:0]        v_pos;
    logic                 h_at_min, h_at_max, h_at_tgt;
    logic                 v_at_min, v_at_max, v_at_tgt;
    logic                 odd_row, row_end;
    logic [V_WIDTH:0]     v_plus_hyst;
    logic                 track_low;

    sweep_axis #(.STEPS(STEPS_H), .W(HW)) u_axis_h (
        .clk       (CLK),
        .rst       (RESET),
        .step_req  (step_h),
        .step_dir  (dir_h_req),
        .target    (peak_h_q),
        .pos       (h_pos),
        .move      (MOVE_H),
        .dir       (DIR_H),
        .at_min    (h_at_min),
        .at_max    (h_at_max),
        .at_target (h_at_tgt)
    );

    sweep_axis #(.STEPS(STEPS_V), .W(VW)) u_axis_v (
        .clk       (CLK),
        .rst       (RESET),
        .step_req  (step_v),
        .step_dir  (dir_v_req),
        .target    (peak_vp_q),
        .pos       (v_pos),
        .move      (MOVE_V),
        .dir       (DIR_V),
        .at_min    (v_at_min),
        .at_max    (v_at_max),
        .at_target (v_at_tgt)
    );

    // Serpentine: even rows run H upward, odd rows run H downward.
    assign odd_row = v_pos[0];
    assign row_end = odd_row ? h_at_min : h_at_max;

    // One extra bit so V_IN + HYST cannot wrap near full scale.
    assign v_plus_hyst = {1'b0, V_IN} + HYST_EXT;
    assign track_low   = (v_plus_hyst < {1'b0, peak_v_q});

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        miss_d    = miss_q;
        peak_v_d  = peak_v_q;
        peak_h_d  = peak_h_q;
        peak_vp_d = peak_vp_q;
        step_h    = 1'b0;
        dir_h_req = 1'b0;
        step_v    = 1'b0;
        dir_v_req = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_HOME;
                end
            end
            ST_HOME: begin
                if (TICK) begin
                    if (!h_at_min) begin
                        step_h = 1'b1;
                    end else if (!v_at_min) begin
                        step_v = 1'b1;
                    end else begin
                        peak_v_d  = '0;
                        peak_h_d  = '0;
                        peak_vp_d = '0;
                        settle_d  = '0;
                        state_d   = ST_SETTLE;
                    end
                end
            end
            ST_SETTLE: begin
                if (TICK) begin
                    if (settle_q == SETTLE_LAST) begin
                        settle_d = '0;
                        state_d  = ST_SAMPLE;
                    end else begin
                        settle_d = settle_q + SW'(1);
                    end
                end
            end
            ST_SAMPLE: begin
                // A TICK arriving with V_VALID is consumed by the sample only.
                if (V_VALID) begin
                    if (V_IN > peak_v_q) begin
                        peak_v_d  = V_IN;
                        peak_h_d  = h_pos;
                        peak_vp_d = v_pos;
                    end
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (row_end && v_at_max) begin
                    state_d = ST_RETURN;
                end else if (TICK) begin
                    if (!row_end) begin
                        step_h    = 1'b1;
                        dir_h_req = !odd_row;
                    end else begin
                        step_v    = 1'b1;
                        dir_v_req = 1'b1;
                    end
                    state_d = ST_SETTLE;
                end
            end
            ST_RETURN: begin
                if (h_at_tgt && v_at_tgt) begin
                    miss_d  = '0;
                    state_d = ST_TRACK;
                end else if (TICK) begin
                    if (!h_at_tgt) begin
                        step_h    = 1'b1;
                        dir_h_req = (h_pos < peak_h_q);
                    end else begin
                        step_v    = 1'b1;
                        dir_v_req = (v_pos < peak_vp_q);
                    end
                end
            end
            ST_TRACK: begin
                if (START) begin
                    miss_d  = '0;
                    state_d = ST_HOME;
                end else if (V_VALID) begin
                    if (track_low) begin
                        if (miss_q == MISS_LAST) begin
                            miss_d  = '0;
                            state_d = ST_HOME;
                        end else begin
                            miss_d = miss_q + MW'(1);
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_TRACK) && (state_q != ST_TRACK);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            settle_q  <= '0;
            miss_q    <= '0;
            peak_v_q  <= '0;
            peak_h_q  <= '0;
            peak_vp_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            miss_q    <= miss_d;
            peak_v_q  <= peak_v_d;
            peak_h_q  <= peak_h_d;
            peak_vp_q <= peak_vp_d;
            done_q    <= done_d;
        end
    end

    assign BUSY       = (state_q != ST_IDLE) && (state_q != ST_TRACK);
    assign DONE       = done_q;
    assign PEAK_V     = peak_v_q;
    assign PEAK_H_POS = peak_h_q;
    assign PEAK_V_POS = peak_vp_q;
    assign STAT       = state_q;

endmodule

// File: tb/tb_sweep_tracker.sv
// tb/tb_sweep_tracker.sv - self-checking bench for sweep_tracker
module tb_sweep_tracker;

    localparam int VW = 12;
    localparam int SH = 4;
    localparam int SV = 2;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          TICK = 1'b0;
    logic          START = 1'b0;
    logic          V_VALID = 1'b0;
    logic [VW-1:0] V_IN = '0;
    logic          MOVE_H, MOVE_V, DIR_H, DIR_V, BUSY, DONE;
    logic [VW-1:0] PEAK_V;
    logic [1:0]    PEAK_H_POS;
    logic [0:0]    PEAK_V_POS;
    logic [2:0]    STAT;

    sweep_tracker #(
        .V_WIDTH(VW), .STEPS_H(SH), .STEPS_V(SV),
        .SETTLE(1), .HYST(8), .MISS_MAX(3)
    ) dut (
        .CLK(CLK), .RESET(RESET), .TICK(TICK), .START(START),
        .V_IN(V_IN), .V_VALID(V_VALID),
        .MOVE_H(MOVE_H), .MOVE_V(MOVE_V), .DIR_H(DIR_H), .DIR_V(DIR_V),
        .BUSY(BUSY), .DONE(DONE), .PEAK_V(PEAK_V),
        .PEAK_H_POS(PEAK_H_POS), .PEAK_V_POS(PEAK_V_POS), .STAT(STAT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Scene and expectation model.
    int grid [SH][SV];
    int exp_q[$];            // expected moves: axis*2 + dir (axis 1 = V)
    int exp_pv, exp_ph, exp_pvp;
    int model_h = 0, model_v = 0;
    int samples = 0;
    int done_cnt = 0;
    int prev_stat = 0;

    // Stimulus control shared with the generator.
    int track_mode = 0;
    int hold20 = 0;
    int trk_val = 0;
    int trk_seq = 0;
    int trk_done = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic set_grid(input int base, input int h1, input int v1, input int val1,
                            input int h2, input int v2, input int val2);
        for (int h = 0; h < SH; h++)
            for (int v = 0; v < SV; v++)
                grid[h][v] = base;
        grid[h1][v1] = val1;
        grid[h2][v2] = val2;
    endtask

    // Queue the moves a full rescan must produce from the current position:
    // homing, serpentine sweep, then return to the best (first strict max) point.
    task automatic push_scan();
        int h, eh, ev;
        for (int i = 0; i < model_h; i++) exp_q.push_back(0);
        for (int i = 0; i < model_v; i++) exp_q.push_back(2);
        exp_pv = 0; exp_ph = 0; exp_pvp = 0;
        for (int v = 0; v < SV; v++) begin
            for (int k = 0; k < SH; k++) begin
                h = (v % 2 == 0) ? k : SH - 1 - k;
                if (grid[h][v] > exp_pv) begin
                    exp_pv = grid[h][v]; exp_ph = h; exp_pvp = v;
                end
                if (k < SH - 1) exp_q.push_back((v % 2 == 0) ? 1 : 0);
            end
            if (v < SV - 1) exp_q.push_back(3);
        end
        eh = ((SV - 1) % 2 == 0) ? SH - 1 : 0;
        ev = SV - 1;
        while (eh != exp_ph) begin
            exp_q.push_back((eh < exp_ph) ? 1 : 0);
            eh = (eh < exp_ph) ? eh + 1 : eh - 1;
        end
        while (ev != exp_pvp) begin
            exp_q.push_back((ev < exp_pvp) ? 3 : 2);
            ev = (ev < exp_pvp) ? ev + 1 : ev - 1;
        end
    endtask

    // Generator: TICK every 4 cycles; V_VALID either periodic from the scene
    // or a single directed sample while tracking.
    initial begin
        forever begin
            @(negedge CLK);
            cyc++;
            TICK = (cyc % 4 == 0);
            if (track_mode != 0) begin
                if (trk_seq != trk_done) begin
                    V_VALID = 1'b1;
                    V_IN = VW'(trk_val);
                    trk_done = trk_seq;
                end else begin
                    V_VALID = 1'b0;
                end
            end else begin
                V_VALID = (cyc % 3 == 0) && !(hold20 != 0 && model_h == 2 && model_v == 0);
                V_IN = VW'(grid[model_h][model_v]);
            end
        end
    end

    // Per-cycle compare against the model.
    initial begin
        int e;
        forever begin
            @(posedge CLK);
            #1;
            if (RESET) begin
                model_h = 0; model_v = 0; samples = 0; prev_stat = 0;
                exp_q.delete();
            end else begin
                check("one_axis", int'(MOVE_H & MOVE_V), 0);
                if (MOVE_H || MOVE_V) begin
                    check("move_on_tick", int'(TICK), 1);
                    check("move_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("move_axis_dir", int'({MOVE_V, MOVE_V ? DIR_V : DIR_H}), e);
                    end
                    if (MOVE_H) model_h = DIR_H ? model_h + 1 : model_h - 1;
                    else        model_v = DIR_V ? model_v + 1 : model_v - 1;
                    if (model_h < 0 || model_h >= SH) model_h = 0;
                    if (model_v < 0 || model_v >= SV) model_v = 0;
                end
                check("busy", int'(BUSY), int'(STAT != 0 && STAT != 6));
                check("done", int'(DONE), int'(STAT == 6 && prev_stat != 6));
                if (prev_stat == 3 && V_VALID) samples++;
                if (prev_stat == 1 && STAT == 2) begin
                    check("peak_cleared", int'(PEAK_V) + int'(PEAK_H_POS) + int'(PEAK_V_POS), 0);
                    samples = 0;
                end
                if (DONE) begin
                    check("sample_count", samples, SH * SV);
                    check("done_peak_v", int'(PEAK_V), exp_pv);
                    check("done_peak_h", int'(PEAK_H_POS), exp_ph);
                    check("done_peak_vp", int'(PEAK_V_POS), exp_pvp);
                    check("done_at_peak", model_h * 8 + model_v, exp_ph * 8 + exp_pvp);
                    done_cnt++;
                end
                prev_stat = int'(STAT);
            end
        end
    end

    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        check("start_to_home", int'(STAT), 1);
    endtask

    task automatic wait_done(input int limit);
        int target, reached;
        target = done_cnt + 1;
        reached = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge CLK);
            if (done_cnt >= target) begin
                reached = 1;
                break;
            end
        end
        check("done_seen", reached, 1);
    endtask

    task automatic track_sample(input int val);
        int got;
        trk_val = val;
        trk_seq++;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (trk_done == trk_seq) begin
                got = 1;
                break;
            end
        end
        check("track_sample_sent", got, 1);
        @(negedge CLK);
    endtask

    task automatic check_peak(input string tag, input int pv, input int ph, input int pvp);
        check({tag, "_peak_v"}, int'(PEAK_V), pv);
        check({tag, "_peak_h"}, int'(PEAK_H_POS), ph);
        check({tag, "_peak_vp"}, int'(PEAK_V_POS), pvp);
        check({tag, "_stat"}, int'(STAT), 6);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int reached;
        // Reset state.
        repeat (3) @(negedge CLK);
        check("rst_stat", int'(STAT), 0);
        check("rst_outs", int'({MOVE_H, MOVE_V, DIR_H, DIR_V, BUSY, DONE}), 0);
        check("rst_peak", int'(PEAK_V), 0);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("idle_stat", int'(STAT), 0);
        check("idle_busy", int'(BUSY), 0);

        // Scan with a single bright point; START mid-sweep must be ignored.
        set_grid(1000, 2, 1, 3000, 2, 1, 3000);
        push_scan();
        check("model_a_pv", exp_pv, 3000);
        check("model_a_pos", exp_ph * 8 + exp_pvp, 2 * 8 + 1);
        pulse_start();
        repeat (20) @(negedge CLK);
        check("mid_sweep_busy", int'(BUSY), 1);
        START = 1'b1;
        repeat (3) @(negedge CLK);
        START = 1'b0;
        wait_done(800);
        check_peak("scan_a", 3000, 2, 1);

        // Forced rescan from TRACK at (2,1): H down twice, then V down once.
        push_scan();
        check("home_seq", exp_q[0] * 100 + exp_q[1] * 10 + exp_q[2], 2);
        pulse_start();
        wait_done(800);
        check_peak("rescan_a", 3000, 2, 1);

        // Tracking hysteresis and miss counter.
        track_mode = 1;
        for (int i = 0; i < 5; i++) begin
            track_sample(2992);
            check("track_2992", int'(STAT), 6);
        end
        track_sample(2991); check("track_miss1", int'(STAT), 6);
        track_sample(2991); check("track_miss2", int'(STAT), 6);
        track_sample(3000); check("track_clear", int'(STAT), 6);
        track_sample(2991); check("track_miss1b", int'(STAT), 6);
        track_sample(2991); check("track_miss2b", int'(STAT), 6);
        set_grid(500, 1, 0, 2000, 3, 0, 2000);
        push_scan();
        check("model_tie_pv", exp_pv, 2000);
        check("model_tie_pos", exp_ph * 8 + exp_pvp, 1 * 8 + 0);
        track_sample(2991);
        check("miss3_home", int'(STAT), 1);
        check("miss3_busy", int'(BUSY), 1);
        track_mode = 0;
        wait_done(800);
        check_peak("tie", 2000, 1, 0);

        // Reset while sampling at (2,0).
        set_grid(1000, 2, 1, 3000, 2, 1, 3000);
        push_scan();
        hold20 = 1;
        pulse_start();
        reached = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            if (STAT == 3'd3 && model_h == 2 && model_v == 0) begin
                reached = 1;
                break;
            end
        end
        check("reached_sample_20", reached, 1);
        check("pre_reset_peak", int'(PEAK_V), 1000);
        RESET = 1'b1;
        #1;
        check("async_rst_stat", int'(STAT), 0);
        check("async_rst_peak", int'(PEAK_V), 0);
        check("async_rst_outs", int'({MOVE_H, MOVE_V, BUSY, DONE}), 0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        hold20 = 0;
        @(negedge CLK);
        push_scan();
        pulse_start();
        wait_done(800);
        check_peak("post_reset", 3000, 2, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
